// File: rtl/demux2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake and a 2-entry FIFO per output port.
// Optional per-port accepted-word counters are compiled in with DEMUX2_STATS_EN.
module demux2_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX2_STATS_EN
  ,
  output logic [15:0]      count0,
  output logic [15:0]      count1
`endif
);

  localparam int unsigned NPORT = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_t;

  fifo_state_t                   state_q [NPORT];
  fifo_state_t                   state_d [NPORT];
  logic [NPORT-1:0][WIDTH-1:0]   head_q;
  logic [NPORT-1:0][WIDTH-1:0]   head_d;
  logic [NPORT-1:0][WIDTH-1:0]   tail_q;
  logic [NPORT-1:0][WIDTH-1:0]   tail_d;
  logic [NPORT-1:0]              enq;
  logic [NPORT-1:0]              deq;
  logic [NPORT-1:0]              out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // Depends only on sel and registered state, never on the consumers' ready.
  assign in_ready = (state_q[sel] != TWO);

  assign out0_valid = (state_q[0] != EMPTY);
  assign out1_valid = (state_q[1] != EMPTY);
  assign out0_data  = head_q[0];
  assign out1_data  = head_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NPORT; k++) begin
        state_q[k] <= EMPTY;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        state_q[k] <= state_d[k];
      end
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Per-port next state and buffer contents.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    enq    = '0;
    deq    = '0;
    for (int k = 0; k < NPORT; k++) begin
      state_d[k] = state_q[k];
      enq[k]     = in_valid && in_ready && (sel == 1'(k));
      deq[k]     = (state_q[k] != EMPTY) && out_ready[k];
      case (state_q[k])
        EMPTY: begin
          if (enq[k]) begin
            state_d[k] = ONE;
            head_d[k]  = in_data;
          end
        end
        ONE: begin
          case ({enq[k], deq[k]})
            2'b10: begin
              state_d[k] = TWO;
              tail_d[k]  = in_data;
            end
            2'b01: state_d[k] = EMPTY;
            2'b11: head_d[k] = in_data;
            default: ;
          endcase
        end
        TWO: begin
          if (deq[k]) begin
            state_d[k] = ONE;
            head_d[k]  = tail_q[k];
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

`ifdef DEMUX2_STATS_EN
  // Free-running wrap-around enqueue counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      count0 <= 16'd0;
      count1 <= 16'd0;
    end else begin
      if (enq[0]) count0 <= count0 + 16'd1;
      if (enq[1]) count1 <= count1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// Self-checking bench for demux2_reg using queue-based port models.
// Counter checks are compiled in when DEMUX2_STATS_EN is defined.
module tb_demux2_reg;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             sel = 1'b0;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX2_STATS_EN
  logic [15:0]      count0;
  logic [15:0]      count1;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] got0[$];
  logic [WIDTH-1:0] got1[$];
  int unsigned      m_cnt0 = 0;
  int unsigned      m_cnt1 = 0;
  logic             last_acc = 1'b0;

  demux2_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX2_STATS_EN
    ,
    .count0     (count0),
    .count1     (count1)
`endif
  );

  always #5 clk = ~clk;

  // One clock: compare against the queue model before and after the edge.
  task automatic step();
    logic acc;
    logic d0;
    logic d1;
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = sel ? (q1.size() < 2) : (q0.size() < 2);
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL in_ready got=%b exp=%b sel=%b", in_ready, exp_rdy, sel);
    end
    acc = in_valid && exp_rdy && !reset;
    d0  = (q0.size() > 0) && out0_ready && !reset;
    d1  = (q1.size() > 0) && out1_ready && !reset;
    if (d0 && out0_valid) got0.push_back(out0_data);
    if (d1 && out1_valid) got1.push_back(out1_data);
    @(posedge clk);
    if (reset) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (acc) begin
        if (sel) begin q1.push_back(in_data); m_cnt1++; end
        else     begin q0.push_back(in_data); m_cnt0++; end
      end
    end
    last_acc = acc;
    #1;
    total++;
    if (out0_valid !== (q0.size() > 0) || (q0.size() > 0 && out0_data !== q0[0])) begin
      bad++;
      $display("FAIL port0 got v=%b d=%h exp v=%b d=%h", out0_valid, out0_data,
               q0.size() > 0, (q0.size() > 0) ? q0[0] : '0);
    end
    total++;
    if (out1_valid !== (q1.size() > 0) || (q1.size() > 0 && out1_data !== q1[0])) begin
      bad++;
      $display("FAIL port1 got v=%b d=%h exp v=%b d=%h", out1_valid, out1_data,
               q1.size() > 0, (q1.size() > 0) ? q1[0] : '0);
    end
`ifdef DEMUX2_STATS_EN
    total++;
    if (count0 !== 16'(m_cnt0) || count1 !== 16'(m_cnt1)) begin
      bad++;
      $display("FAIL counters got=%0d/%0d exp=%0d/%0d", count0, count1,
               16'(m_cnt0), 16'(m_cnt1));
    end
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    got0.delete();
    got1.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    total++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b%b d0=%h d1=%h exp all 0", out0_valid, out1_valid,
               out0_data, out1_data);
    end
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
  endtask

  task automatic test_route();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid = 1'b1; sel = 1'b0; in_data = 32'hDEADBEEF;
    step();
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF || out1_valid !== 1'b0) begin
      bad++;
      $display("FAIL route0 got v0=%b d0=%h v1=%b exp 1 deadbeef 0", out0_valid, out0_data, out1_valid);
    end
    sel = 1'b1; in_data = 32'h12345678;
    step();
    total++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h12345678 || out0_valid !== 1'b0) begin
      bad++;
      $display("FAIL route1 got v1=%b d1=%h v0=%b exp 1 12345678 0", out1_valid, out1_data, out0_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_full();
    int n;
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    in_valid = 1'b1; sel = 1'b0;
    in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_data = 32'hC;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready got=%b exp=0", in_ready);
    end
    sel = 1'b1; in_data = 32'h55;
    step();
    total++;
    if (last_acc !== 1'b1 || out1_data !== 32'h55) begin
      bad++;
      $display("FAIL other_port got acc=%b d1=%h exp 1 55", last_acc, out1_data);
    end
    sel = 1'b0; in_data = 32'hC; out0_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 20);
    in_valid = 1'b0;
    repeat (4) step();
    total++;
    if (got0.size() != 3 || got0[0] !== 32'hA || got0[1] !== 32'hB || got0[2] !== 32'hC) begin
      bad++;
      $display("FAIL full_order got n=%0d exp A,B,C", got0.size());
    end
  endtask

  task automatic test_back_to_back();
    int ok;
    do_reset();
    out1_ready = 1'b1;
    in_valid = 1'b1; sel = 1'b1;
    ok = 1;
    for (int i = 1; i <= 100; i++) begin
      in_data = WIDTH'(i);
      step();
      if (!last_acc) ok = 0;
    end
    in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (ok != 1) begin
      bad++;
      $display("FAIL b2b_rate got stall exp one word per cycle");
    end
    total++;
    if (got1.size() != 100) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=100", got1.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        if (got1[i] !== WIDTH'(i + 1)) begin
          ok = 0;
        end
      end
      total++;
      if (ok != 1) begin
        bad++;
        $display("FAIL b2b_order got out-of-order data exp 1..100");
      end
    end
`ifdef DEMUX2_STATS_EN
    total++;
    if (count1 !== 16'd100 || count0 !== 16'd0) begin
      bad++;
      $display("FAIL b2b_stats got=%0d/%0d exp=0/100", count0, count1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 1'(i & 1);
      in_data = $urandom;
      step();
    end
    total++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL prefill got v=%b%b rdy=%b exp 11 0", out0_valid, out1_valid, in_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got v=%b%b exp 00", out0_valid, out1_valid);
    end
    sel = 1'b1; in_data = 32'hCAFE0001; out1_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

`ifdef DEMUX2_STATS_EN
  task automatic test_wrap();
    do_reset();
    out0_ready = 1'b1;
    in_valid = 1'b1; sel = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      in_data = WIDTH'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    total++;
    if (count0 !== 16'd1) begin
      bad++;
      $display("FAIL wrap got=%0d exp=1", count0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_route();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DEMUX2_STATS_EN
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux2_reg.md
# demux2_reg

Registered 1-to-2 demultiplexer with valid/ready handshake, the distribution counterpart of the 2:1 select mux. It takes one WIDTH-bit transaction stream and steers each accepted word to output port 0 or port 1 according to `sel`, holding it in a per-port 2-entry buffer until that port's consumer accepts it. It sits between the datapath store/write-back source and two independent sinks, such as data memory and a memory-mapped peripheral.

## Interface
- `WIDTH`, 32, data width of every data port.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  source presents a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_data`  in  WIDTH  word to route.
- `sel`  in  1  destination: 0 → port 0, 1 → port 1; sampled with `in_data`.
- `out0_valid`  out  1  port 0 buffer head is valid.
- `out0_ready`  in  1  port 0 consumer accepts the head.
- `out0_data`  out  WIDTH  port 0 buffer head.
- `out1_valid`, `out1_ready`, `out1_data`: same as port 0, for port 1.
- `count0`, `count1`  out  16  accepted-word counters per port (present only with `DEMUX2_STATS_EN`).

## Operation
- Each port k has an independent 2-entry FIFO with states EMPTY, ONE and TWO. `outk_valid` = (state != EMPTY). `outk_data` = head entry, driven from a register.
- `in_ready` = (selected port's state != TWO). It is a combinational function of `sel` and the registered state only. There is no combinational path from `outk_ready` to `in_ready`.
- Enqueue to port k: `in_valid && in_ready && sel==k`. Dequeue from port k: `outk_valid && outk_ready`.
- Transitions per port, written as (enq, deq):
  - EMPTY: (1,–) → ONE.
  - ONE: (1,0) → TWO; (0,1) → EMPTY; (1,1) → ONE, with the new word becoming head.
  - TWO: (0,1) → ONE, with the second entry moving to head. Enqueue is impossible in TWO because `in_ready`=0.
- Ordering is preserved within a port. No ordering is implied between ports. Both ports may dequeue in the same cycle.
- `in_data` is captured unmodified. Only the selected port is written. The other port's state and data do not change.
- When `in_valid`=0, `sel` and `in_data` are don't-care and do not affect state.

## Timing
- Reset values: `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=0, `in_ready`=1 for either `sel`, `count0`=`count1`=0.
- Latency: a word accepted at edge N is visible on `outk_data`, with `outk_valid`=1, in the cycle after edge N.
- Throughput: 1 word/cycle into a port whose consumer holds `outk_ready`=1 continuously.
- Full: when a port is in TWO and `outk_ready`=0, `in_ready`=0 for that `sel`. The source must hold `in_valid`/`in_data`/`sel` stable until accepted. The other port remains usable.
- Reset asserted mid-operation discards all buffered entries at that edge. Words accepted in the reset cycle are dropped.
- Dequeue with `outk_valid`=0 has no effect.

## Configuration
- `DEMUX2_STATS_EN` defined:
  - `count0`/`count1` ports exist.
  - `countk` increments by 1 on each enqueue to port k.
  - Each counter wraps from 16'hFFFF to 16'h0000.
  - Each counter is cleared by `reset`.
- `DEMUX2_STATS_EN` undefined: counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle → `out0_valid`=`out1_valid`=0, both data outputs 0, `in_ready`=1 for `sel`=0 and 1.
- Send 32'hDEADBEEF with `sel`=0, then 32'h12345678 with `sel`=1, both consumers ready → each word appears on its own port exactly one cycle after acceptance; the other port stays invalid.
- `out0_ready`=0, send 0xA, 0xB, 0xC on `sel`=0 → 0xA and 0xB accepted, `in_ready`=0 while presenting 0xC; a `sel`=1 word is still accepted. Raise `out0_ready` → 0xA, 0xB, 0xC are delivered in order.
- Back-to-back stream 1..100 on `sel`=1 with `out1_ready`=1 → one word accepted per cycle, none lost, order kept. With `DEMUX2_STATS_EN`, `count1`=100 and `count0`=0.
- Fill both ports to TWO, then assert `reset` for one cycle → both valids are 0 the next cycle, and subsequent traffic behaves as after a fresh reset.
- With `DEMUX2_STATS_EN`, 65537 accepted words on port 0 → `count0`=1.
